// File: rtl/down_count_timer_pkg.sv
// Shared types for the loadable down-count timer: FSM state encoding and defaults.
// The unused state code 2'b11 is treated as IDLE by the FSM.
package down_count_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    DONE    = 2'b10
  } timer_state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Collapses the unused encoding onto IDLE so a corrupted state self-recovers.
  function automatic timer_state_t sanitize_state(input timer_state_t s);
    return (s == RUNNING || s == DONE) ? s : IDLE;
  endfunction

endpackage

// File: rtl/down_count_reg.sv
// WIDTH-bit count register with clear > load > decrement > hold priority.
// Single-cycle update; the FSM guarantees dec is never raised at zero.
module down_count_reg
  import down_count_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_dat,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_dat;
    end else if (dec) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter: counts load_val down to zero, pulses underflow, then stops or reloads.
// Underflow appears N+1 edges after start with load_val=N; each paused cycle adds one.
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             underflow_q, underflow_d;

  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_load_dat;

  down_count_reg #(
    .WIDTH(WIDTH)
  ) u_count (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_dat (cnt_load_dat),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reload_q    <= '0;
      mode_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    mode_d       = mode_q;
    underflow_d  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_dat = load_val;

    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (sanitize_state(state_q))
        IDLE, DONE: begin
          if (start) begin
            cnt_load = 1'b1;
            reload_d = load_val;
            mode_d   = auto_reload;
            state_d  = RUNNING;
          end else if (state_q != DONE) begin
            state_d = IDLE;
          end
        end
        RUNNING: begin
          // Pause wins over the zero check, so a paused timer never underflows.
          if (!pause) begin
            if (count != '0) begin
              cnt_dec = 1'b1;
            end else begin
              underflow_d = 1'b1;
              if (mode_q) begin
                cnt_load     = 1'b1;
                cnt_load_dat = reload_q;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RUNNING);
    done = (state_q == DONE);
  end

  assign underflow = underflow_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed bench for down_count_timer: one task per scenario, hand-computed expectations.
module tb_down_count_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] load_val;
  logic       start;
  logic       auto_reload;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       underflow;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  down_count_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_val    (load_val),
    .start       (start),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .count       (count),
    .underflow   (underflow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] v, input logic ar);
    load_val    = v;
    auto_reload = ar;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_val = 4'd0; start = 1'b0; auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if ({count, underflow, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got count=%0d uf=%b busy=%b done=%b, want 0 0 0 0", count, underflow, busy, done);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    // mid-run asynchronous reset
    do_start(4'd5, 1'b0);
    checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_load5: got count=%0d busy=%b, want 5 1", count, busy);
    end
    tick(); tick();
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL two_decrements: got count=%0d, want 3", count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || underflow !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d busy=%b uf=%b done=%b, want 0 0 0 0", count, busy, underflow, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got count=%0d busy=%b, want 0 0", count, busy);
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_cnt [3] = '{4'd2, 4'd1, 4'd0};
    do_start(4'd3, 1'b0);
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_load: got count=%0d busy=%b, want 3 1", count, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== exp_cnt[i] || underflow !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_dec[%0d]: got count=%0d uf=%b busy=%b, want %0d 0 1", i, count, underflow, busy, exp_cnt[i]);
      end
    end
    tick();
    checks++;
    if (count !== 4'd0 || underflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_underflow: got count=%0d uf=%b done=%b busy=%b, want 0 1 1 0", count, underflow, done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== 4'd0 || underflow !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_hold[%0d]: got count=%0d uf=%b done=%b, want 0 0 1", i, count, underflow, done);
      end
    end
    do_start(4'd1, 1'b0);
    checks++;
    if (count !== 4'd1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: got count=%0d done=%b busy=%b, want 1 0 1", count, done, busy);
    end
    tick(); tick();
    checks++;
    if (underflow !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL restart_underflow: got uf=%b done=%b, want 1 1", underflow, done);
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_cnt [6] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    logic       exp_uf  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_start(4'd2, 1'b1);
    checks++;
    if (count !== 4'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL reload_load: got count=%0d done=%b, want 2 0", count, done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (count !== exp_cnt[i] || underflow !== exp_uf[i] || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_seq[%0d]: got count=%0d uf=%b done=%b busy=%b, want %0d %b 0 1",
                 i, count, underflow, done, busy, exp_cnt[i], exp_uf[i]);
      end
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reload_abort: got count=%0d busy=%b uf=%b, want 0 0 0", count, busy, underflow);
    end
  endtask

  task automatic test_pause();
    do_start(4'd4, 1'b0);
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'd2 || busy !== 1'b1 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold[%0d]: got count=%0d busy=%b uf=%b, want 2 1 0", i, count, busy, underflow);
      end
    end
    pause = 1'b0;
    tick(); tick();
    checks++;
    if (count !== 4'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume: got count=%0d uf=%b, want 0 0", count, underflow);
    end
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 4'd0 || underflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL pause_at_zero[%0d]: got count=%0d uf=%b busy=%b done=%b, want 0 0 1 0", i, count, underflow, busy, done);
      end
    end
    pause = 1'b0;
    tick();
    checks++;
    if (underflow !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL pause_release_uf: got uf=%b done=%b, want 1 1", underflow, done);
    end
  endtask

  task automatic test_abort_and_ignore();
    do_start(4'd7, 1'b0);
    checks++;
    if (count !== 4'd7 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_load7: got count=%0d done=%b, want 7 0", count, done);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_running: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
    load_val = 4'd6; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: got count=%0d busy=%b, want 0 0", count, busy);
    end
    do_start(4'd5, 1'b0);
    tick();
    load_val = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: got count=%0d busy=%b, want 3 1", count, busy);
    end
    tick();
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL keep_decrementing: got count=%0d, want 2", count);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_boundaries();
    do_start(4'd15, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (count !== 4'(15 - i) || underflow !== 1'b0) begin
        errors++;
        $display("FAIL max_dec[%0d]: got count=%0d uf=%b, want %0d 0", i, count, underflow, 15 - i);
      end
    end
    tick();
    checks++;
    if (count !== 4'd0 || underflow !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL max_underflow: got count=%0d uf=%b done=%b, want 0 1 1", count, underflow, done);
    end
    do_start(4'd0, 1'b0);
    checks++;
    if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_load: got count=%0d busy=%b done=%b, want 0 1 0", count, busy, done);
    end
    tick();
    checks++;
    if (underflow !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_oneshot: got uf=%b done=%b busy=%b, want 1 1 0", underflow, done, busy);
    end
    do_start(4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (underflow !== 1'b1 || count !== 4'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL zero_reload[%0d]: got uf=%b count=%0d busy=%b, want 1 0 1", i, underflow, count, busy);
      end
    end
    pause = 1'b1; tick(); pause = 1'b0;
    checks++;
    if (underflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_reload_pause: got uf=%b busy=%b, want 0 1", underflow, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_abort_and_ignore();
    test_boundaries();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
